wb_bus_arbiter: RTL and testbench



---
 rtl/wb_bus_arbiter_if.sv | 56 +++++
 rtl/wb_bus_arbiter.sv | 98 +++++++++
 tb/tb_wb_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared slave.
// The arbiter connects through the slave modport; the master modport is the surrounding system's view.
interface wb_bus_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  localparam int unsigned SW = DW / 8;

  logic          m0_stb_i;
  logic          m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_i;
  logic [SW-1:0] m0_sel_i;
  logic [DW-1:0] m0_dat_o;
  logic          m0_ack_o;
  logic          m0_err_o;

  logic          m1_stb_i;
  logic          m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i;
  logic [SW-1:0] m1_sel_i;
  logic [DW-1:0] m1_dat_o;
  logic          m1_ack_o;
  logic          m1_err_o;

  logic          s_stb_o;
  logic          s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;

  logic [1:0]    gnt_o;

  modport slave (
    input  m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i,
    output gnt_o
  );

  modport master (
    output m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i,
    input  gnt_o
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin arbiter for a single stb/ack slave: one transfer at a time,
// a forced gap cycle after every transfer and a timeout for hung slaves.
module wb_bus_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned TO_CYCLES = 255,
  parameter int unsigned TO_W      = 8
) (
  input  logic              clk,
  input  logic              rst_ni,
  wb_bus_arbiter_if.slave   bus
);
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_gnt;
  logic            r_last;
  logic [TO_W-1:0] r_tcnt;

  logic            w_busy;
  logic            w_stb;
  logic            w_ack;
  logic            w_tmo;
  logic            w_done;
  logic            w_we;
  logic [AW-1:0]   w_adr;
  logic [DW-1:0]   w_wdat;
  logic [SW-1:0]   w_sel;
  logic [DW-1:0]   w_rdat;

  // Request mux for the current owner and transfer-termination conditions
  always_comb begin
    w_busy = (r_state == ST_BUSY);
    w_stb  = r_gnt ? bus.m1_stb_i : bus.m0_stb_i;
    w_we   = r_gnt ? bus.m1_we_i  : bus.m0_we_i;
    w_adr  = r_gnt ? bus.m1_adr_i : bus.m0_adr_i;
    w_wdat = r_gnt ? bus.m1_dat_i : bus.m0_dat_i;
    w_sel  = r_gnt ? bus.m1_sel_i : bus.m0_sel_i;
    w_ack  = w_busy & w_stb & bus.s_ack_i;
    // A slave ack in the last allowed cycle still counts as a normal completion
    w_tmo  = w_busy & w_stb & ~bus.s_ack_i & (r_tcnt == TO_W'(TO_CYCLES - 1));
    w_done = w_busy & (w_ack | w_tmo | ~w_stb);
    w_rdat = w_tmo ? '0 : bus.s_dat_i;
  end

  // Slave-side and master-side outputs, all quiet outside BUSY
  always_comb begin
    bus.s_stb_o  = w_busy & w_stb & ~w_tmo;
    bus.s_we_o   = w_busy & w_we;
    bus.s_adr_o  = w_busy ? w_adr  : '0;
    bus.s_dat_o  = w_busy ? w_wdat : '0;
    bus.s_sel_o  = w_busy ? w_sel  : '0;

    bus.m0_ack_o = (w_ack | w_tmo) & ~r_gnt;
    bus.m0_err_o = w_tmo & ~r_gnt;
    bus.m0_dat_o = (w_busy & ~r_gnt) ? w_rdat : '0;
    bus.m1_ack_o = (w_ack | w_tmo) & r_gnt;
    bus.m1_err_o = w_tmo & r_gnt;
    bus.m1_dat_o = (w_busy & r_gnt) ? w_rdat : '0;

    bus.gnt_o    = w_busy ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
  end

  // Arbitration state machine
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.m0_stb_i | bus.m1_stb_i) begin
            r_gnt   <= (bus.m0_stb_i & bus.m1_stb_i) ? ~r_last : bus.m1_stb_i;
            r_tcnt  <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_tcnt <= r_tcnt + TO_W'(1);
          if (w_done) begin
            r_last  <= r_gnt;
            r_state <= ST_GAP;
          end
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed testbench for wb_bus_arbiter; DUT built with TO_CYCLES=4.
module tb_wb_bus_arbiter;
  logic clk;
  logic rst_ni;
  int   checks;
  int   errors;

  wb_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  wb_bus_arbiter #(.AW(32), .DW(32), .TO_CYCLES(4), .TO_W(8)) dut (
    .clk    (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_sel_i = '0;
    bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_sel_i = '0;
    bus.s_dat_i  = '0;   bus.s_ack_i = 1'b0;
  endtask

  // Returns at a falling edge just after one reset edge; state is IDLE
  task automatic apply_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    bus.m0_stb_i = 1'b1;
    bus.m1_stb_i = 1'b1;
    bus.s_ack_i  = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.s_stb_o, bus.s_we_o, bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000",
        {bus.s_stb_o, bus.s_we_o, bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o});
    end
    checks++;
    if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", bus.gnt_o); end
    checks++;
    if ({bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.m0_dat_o, bus.m1_dat_o} !== '0) begin
      errors++; $display("FAIL reset_data: got adr=%h dat=%h sel=%h want zeros", bus.s_adr_o, bus.s_dat_o, bus.s_sel_o);
    end
    clear_inputs();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    apply_reset();
    bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h0000_0100; bus.m0_sel_i = 4'hF;
    #1;
    checks++;
    if (bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL rd_idle_stb: got %b want 0", bus.s_stb_o); end
    @(negedge clk); #1;
    checks++;
    if (bus.s_stb_o !== 1'b1 || bus.gnt_o !== 2'b01) begin
      errors++; $display("FAIL rd_busy1: got stb=%b gnt=%b want stb=1 gnt=01", bus.s_stb_o, bus.gnt_o);
    end
    checks++;
    if (bus.s_adr_o !== 32'h100 || bus.s_we_o !== 1'b0 || bus.m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL rd_busy1_req: got adr=%h we=%b ack=%b want 100/0/0", bus.s_adr_o, bus.s_we_o, bus.m0_ack_o);
    end
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hCAFE_F00D;
    #1;
    checks++;
    if (bus.s_stb_o !== 1'b1 || bus.m0_ack_o !== 1'b1 || bus.m0_err_o !== 1'b0 || bus.m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL rd_ack: got stb=%b ack0=%b err0=%b ack1=%b want 1/1/0/0",
        bus.s_stb_o, bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o);
    end
    checks++;
    if (bus.m0_dat_o !== 32'hCAFE_F00D || bus.m1_dat_o !== 32'h0) begin
      errors++; $display("FAIL rd_data: got m0=%h m1=%h want cafef00d/0", bus.m0_dat_o, bus.m1_dat_o);
    end
    @(negedge clk);
    bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b0;
    #1;
    checks++;
    if (bus.s_stb_o !== 1'b0 || bus.m0_ack_o !== 1'b0 || bus.gnt_o !== 2'b00) begin
      errors++; $display("FAIL rd_gap: got stb=%b ack=%b gnt=%b want 0/0/00", bus.s_stb_o, bus.m0_ack_o, bus.gnt_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic       exp_a0;
    logic       exp_a1;
    int         owner;
    apply_reset();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h1234_5678;
    bus.m0_stb_i = 1'b1; bus.m1_stb_i = 1'b1;
    // Each transfer is IDLE, BUSY, GAP; owners alternate starting with m0
    for (int c = 0; c < 12; c++) begin
      #1;
      owner   = (c / 3) % 2;
      exp_gnt = (c % 3 == 1) ? ((owner == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_a0  = (c % 3 == 1) && (owner == 0);
      exp_a1  = (c % 3 == 1) && (owner == 1);
      checks++;
      if (bus.gnt_o !== exp_gnt || bus.m0_ack_o !== exp_a0 || bus.m1_ack_o !== exp_a1) begin
        errors++; $display("FAIL rr_cycle%0d: got gnt=%b ack0=%b ack1=%b want %b/%b/%b",
          c, bus.gnt_o, bus.m0_ack_o, bus.m1_ack_o, exp_gnt, exp_a0, exp_a1);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_write_m1();
    apply_reset();
    bus.m0_adr_i = 32'hDEAD_0000; bus.m0_dat_i = 32'h1111_1111; bus.m0_sel_i = 4'h1;
    bus.m1_stb_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_adr_i = 32'h0000_2003;
    bus.m1_sel_i = 4'b1000; bus.m1_dat_i = 32'hAB00_0000;
    @(negedge clk); #1;
    checks++;
    if (bus.s_we_o !== 1'b1 || bus.s_adr_o !== 32'h2003 || bus.s_sel_o !== 4'b1000 || bus.s_dat_o !== 32'hAB00_0000) begin
      errors++; $display("FAIL wr_req: got we=%b adr=%h sel=%b dat=%h want 1/2003/1000/ab000000",
        bus.s_we_o, bus.s_adr_o, bus.s_sel_o, bus.s_dat_o);
    end
    checks++;
    if (bus.gnt_o !== 2'b10 || bus.s_stb_o !== 1'b1 || bus.m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL wr_gnt: got gnt=%b stb=%b ack0=%b want 10/1/0", bus.gnt_o, bus.s_stb_o, bus.m0_ack_o);
    end
    bus.s_ack_i = 1'b1;
    #1;
    checks++;
    if (bus.m1_ack_o !== 1'b1 || bus.m0_ack_o !== 1'b0 || bus.m1_err_o !== 1'b0) begin
      errors++; $display("FAIL wr_ack: got ack1=%b ack0=%b err1=%b want 1/0/0", bus.m1_ack_o, bus.m0_ack_o, bus.m1_err_o);
    end
    @(negedge clk);
    bus.s_ack_i = 1'b0; bus.m1_stb_i = 1'b0;
    #1;
    checks++;
    if (bus.gnt_o !== 2'b00 || bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL wr_gap: got gnt=%b ack0=%b ack1=%b want 00/0/0", bus.gnt_o, bus.m0_ack_o, bus.m1_ack_o);
    end
    clear_inputs();
  endtask

  task automatic test_timeout(input logic ack_on_last);
    apply_reset();
    bus.m0_stb_i = 1'b1; bus.s_dat_i = 32'h55AA_55AA;
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      if (b == 4) bus.s_ack_i = ack_on_last;
      #1;
      if (b < 4) begin
        checks++;
        if (bus.m0_ack_o !== 1'b0 || bus.s_stb_o !== 1'b1) begin
          errors++; $display("FAIL tmo_busy%0d: got ack=%b stb=%b want 0/1", b, bus.m0_ack_o, bus.s_stb_o);
        end
      end else if (!ack_on_last) begin
        checks++;
        if (bus.m0_ack_o !== 1'b1 || bus.m0_err_o !== 1'b1 || bus.m0_dat_o !== 32'h0 || bus.s_stb_o !== 1'b0) begin
          errors++; $display("FAIL tmo_fire: got ack=%b err=%b dat=%h stb=%b want 1/1/0/0",
            bus.m0_ack_o, bus.m0_err_o, bus.m0_dat_o, bus.s_stb_o);
        end
      end else begin
        checks++;
        if (bus.m0_ack_o !== 1'b1 || bus.m0_err_o !== 1'b0 || bus.m0_dat_o !== 32'h55AA_55AA || bus.s_stb_o !== 1'b1) begin
          errors++; $display("FAIL tmo_ackwins: got ack=%b err=%b dat=%h stb=%b want 1/0/55aa55aa/1",
            bus.m0_ack_o, bus.m0_err_o, bus.m0_dat_o, bus.s_stb_o);
        end
      end
    end
    @(negedge clk);
    bus.m0_stb_i = 1'b0; bus.s_ack_i = 1'b0;
    #1;
    checks++;
    if (bus.m0_ack_o !== 1'b0 || bus.m0_err_o !== 1'b0 || bus.gnt_o !== 2'b00 || bus.s_stb_o !== 1'b0) begin
      errors++; $display("FAIL tmo_gap: got ack=%b err=%b gnt=%b stb=%b want 0/0/00/0",
        bus.m0_ack_o, bus.m0_err_o, bus.gnt_o, bus.s_stb_o);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.gnt_o !== 2'b00 || bus.s_stb_o !== 1'b0) begin
      errors++; $display("FAIL tmo_idle: got gnt=%b stb=%b want 00/0", bus.gnt_o, bus.s_stb_o);
    end
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    bus.m0_stb_i = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.s_stb_o !== 1'b1) begin errors++; $display("FAIL rstb_busy: got stb=%b want 1", bus.s_stb_o); end
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1; bus.m1_stb_i = 1'b1;
    #1;
    checks++;
    if (bus.s_stb_o !== 1'b0 || bus.gnt_o !== 2'b00) begin
      errors++; $display("FAIL rstb_after: got stb=%b gnt=%b want 0/00", bus.s_stb_o, bus.gnt_o);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL rstb_first: got gnt=%b want 01", bus.gnt_o); end
    clear_inputs();
  endtask

  task automatic test_linger();
    apply_reset();
    bus.m0_stb_i = 1'b1;
    @(negedge clk);
    bus.s_ack_i = 1'b1;
    #1;
    checks++;
    if (bus.m0_ack_o !== 1'b1) begin errors++; $display("FAIL lg_ack: got ack=%b want 1", bus.m0_ack_o); end
    @(negedge clk);
    bus.s_ack_i = 1'b0;
    #1;
    checks++;
    if (bus.s_stb_o !== 1'b0 || bus.m0_ack_o !== 1'b0 || bus.gnt_o !== 2'b00) begin
      errors++; $display("FAIL lg_gap: got stb=%b ack=%b gnt=%b want 0/0/00", bus.s_stb_o, bus.m0_ack_o, bus.gnt_o);
    end
    @(negedge clk);
    bus.m0_stb_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.s_stb_o !== 1'b0 || bus.m0_ack_o !== 1'b0) begin
        errors++; $display("FAIL lg_idle%0d: got stb=%b ack=%b want 0/0", c, bus.s_stb_o, bus.m0_ack_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    apply_reset();
    bus.m0_stb_i = 1'b1; bus.s_ack_i = 1'b0;
    @(negedge clk);
    bus.m0_stb_i = 1'b0;
    #1;
    checks++;
    if (bus.m0_ack_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin
      errors++; $display("FAIL ab_drop: got ack=%b stb=%b want 0/0", bus.m0_ack_o, bus.s_stb_o);
    end
    @(negedge clk);
    bus.s_ack_i = 1'b1;
    #1;
    checks++;
    if (bus.gnt_o !== 2'b00 || bus.m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL ab_gap: got gnt=%b ack=%b want 00/0", bus.gnt_o, bus.m0_ack_o);
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_m1();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_busy();
    test_linger();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
